rr_arbiter4: RTL

//  4-requester round-robin arbiter for a shared single-owner resource.

---
 rtl/rr_arbiter4_if.sv | 17 +
 rtl/rr_arbiter4.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if: request/grant bundle between four requesters and rr_arbiter4.
//   req      4  request per requester, held while ownership is wanted
//   gnt      4  registered one-hot grant, zero when idle
//   gnt_id   2  encoded index of the granted requester, zero when idle
//   gnt_vld  1  high while a grant is active
//   timeout  1  one-cycle pulse on a forced release
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;
  logic       timeout;

  modport master (output req, input gnt, gnt_id, gnt_vld, timeout);
  modport slave  (input req, output gnt, gnt_id, gnt_vld, timeout);
endinterface

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-requester round-robin arbiter for a single-owner resource.
// A grant is held for as long as the owner keeps its request high; on release the
// priority pointer moves to the requester after the owner, and at least one idle
// cycle always separates consecutive grants.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_arbiter4_if.slave (req in; gnt, gnt_id, gnt_vld, timeout out)
// Parameters:
//   HOLD_MAX  busy cycles before a forced release (timeout build only)
//   CW        hold counter width, 2**CW must exceed HOLD_MAX
// Build option: define ARB_TIMEOUT_EN to enable the hold counter and forced release.
// Without it, timeout is tied low and an owner may hold the grant forever.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; arbitrate among pending requests starting at ptr
// BUSY  | grant held by owner until its request drops (or timeout)
module rr_arbiter4 #(
  parameter int HOLD_MAX = 15,
  parameter int CW       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_arbiter4_if.slave    bus
);

  if ((2 ** CW) <= HOLD_MAX) begin : g_bad_cw
    $error("rr_arbiter4: CW too narrow for HOLD_MAX");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] owner, owner_nxt;
  logic [3:0] gnt_q, gnt_nxt;
  logic [1:0] gnt_id_q, gnt_id_nxt;
  logic       gnt_vld_q, gnt_vld_nxt;

  // Rotating priority scan: first set request at ptr, ptr+1, ptr+2, ptr+3.
  logic       found;
  logic [1:0] win;
  logic [1:0] idx;

  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX);

  logic [CW-1:0] cnt, cnt_nxt;
  logic          timeout_q, timeout_nxt;
  logic          others_pending;

  assign others_pending = |(bus.req & ~(4'b0001 << owner));
`endif

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    gnt_nxt     = gnt_q;
    gnt_id_nxt  = gnt_id_q;
    gnt_vld_nxt = gnt_vld_q;
`ifdef ARB_TIMEOUT_EN
    cnt_nxt     = cnt;
    timeout_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt   = BUSY;
          owner_nxt   = win;
          gnt_nxt     = 4'b0001 << win;
          gnt_id_nxt  = win;
          gnt_vld_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_nxt     = '0;
`endif
        end
      end
      BUSY: begin
        if (!bus.req[owner]) begin
          state_nxt   = IDLE;
          ptr_nxt     = owner + 2'd1;
          gnt_nxt     = 4'b0000;
          gnt_id_nxt  = 2'd0;
          gnt_vld_nxt = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        // Voluntary release above takes precedence, so timeout stays low then.
        else if ((cnt == CNT_MAX) && others_pending) begin
          state_nxt   = IDLE;
          ptr_nxt     = owner + 2'd1;
          gnt_nxt     = 4'b0000;
          gnt_id_nxt  = 2'd0;
          gnt_vld_nxt = 1'b0;
          timeout_nxt = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      owner     <= 2'd0;
      gnt_q     <= 4'b0000;
      gnt_id_q  <= 2'd0;
      gnt_vld_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      owner     <= owner_nxt;
      gnt_q     <= gnt_nxt;
      gnt_id_q  <= gnt_id_nxt;
      gnt_vld_q <= gnt_vld_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.gnt_vld = gnt_vld_q;

endmodule
